// File: rtl/mult_pipe_param.sv
// mult_pipe_param: NSTAGE-deep shift-add multiplier with valid/ready flow control,
// signed modes via magnitude plus negate flag, and synchronous flush.
module mult_pipe_param #(
   parameter int XLEN   = 64,
   parameter int NSTAGE = 8,
   parameter int TAGW   = 6
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] mcand,
   input  logic [XLEN-1:0] mplier,
   input  logic [1:0]      in_signed,
   input  logic            in_high,
   input  logic [TAGW-1:0] in_tag,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] product,
   output logic [TAGW-1:0] out_tag
);
   localparam int K  = XLEN / NSTAGE;
   localparam int PW = 2 * XLEN;

   logic [NSTAGE-1:0] r_v, r_neg, r_hi;
   logic [PW-1:0]     r_pp  [NSTAGE];
   logic [PW-1:0]     r_a   [NSTAGE];
   logic [XLEN-1:0]   r_b   [NSTAGE];
   logic [TAGW-1:0]   r_tag [NSTAGE];

   logic [NSTAGE-1:0] w_adv, w_iv, w_ineg, w_ihi;
   logic [PW-1:0]     w_ipp  [NSTAGE];
   logic [PW-1:0]     w_ia   [NSTAGE];
   logic [XLEN-1:0]   w_ib   [NSTAGE];
   logic [TAGW-1:0]   w_itag [NSTAGE];
   logic              w_sa, w_sb;
   logic [XLEN-1:0]   w_ma, w_mb;
   logic [PW-1:0]     w_full;

   function automatic logic [PW-1:0] f_acc(input logic [PW-1:0] pp, input logic [PW-1:0] a,
                                           input logic [K-1:0] b);
      logic [PW-1:0] s;
      s = pp;
      for (int j = 0; j < K; j++) s = s + (b[j] ? (a << j) : '0);
      return s;
   endfunction

   assign w_sa = in_signed[1] & mcand[XLEN-1];
   assign w_sb = in_signed[0] & mplier[XLEN-1];
   assign w_ma = w_sa ? -mcand : mcand;
   assign w_mb = w_sb ? -mplier : mplier;

   // A stage moves when any stage from it to the output is empty, or the consumer takes the result.
   always_comb begin
      logic go;
      go = out_ready;
      w_adv = '0;
      for (int s = NSTAGE-1; s >= 0; s--) begin
         go = go || !r_v[s];
         w_adv[s] = go;
      end
   end

   assign in_ready = w_adv[0] && !flush;

   always_comb begin
      w_iv[0]   = in_valid && in_ready;
      w_ipp[0]  = '0;
      w_ia[0]   = {{XLEN{1'b0}}, w_ma};
      w_ib[0]   = w_mb;
      w_ineg[0] = w_sa ^ w_sb;
      w_ihi[0]  = in_high;
      w_itag[0] = in_tag;
      for (int s = 1; s < NSTAGE; s++) begin
         w_iv[s]   = r_v[s-1];
         w_ipp[s]  = r_pp[s-1];
         w_ia[s]   = r_a[s-1];
         w_ib[s]   = r_b[s-1];
         w_ineg[s] = r_neg[s-1];
         w_ihi[s]  = r_hi[s-1];
         w_itag[s] = r_tag[s-1];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_v   <= '0;
         r_neg <= '0;
         r_hi  <= '0;
         for (int s = 0; s < NSTAGE; s++) begin
            r_pp[s]  <= '0;
            r_a[s]   <= '0;
            r_b[s]   <= '0;
            r_tag[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NSTAGE; s++) begin
            if (flush) r_v[s] <= 1'b0;
            else if (w_adv[s]) r_v[s] <= w_iv[s];
            if (!flush && w_adv[s] && w_iv[s]) begin
               r_pp[s]  <= f_acc(w_ipp[s], w_ia[s], w_ib[s][K-1:0]);
               r_a[s]   <= w_ia[s] << K;
               r_b[s]   <= w_ib[s] >> K;
               r_neg[s] <= w_ineg[s];
               r_hi[s]  <= w_ihi[s];
               r_tag[s] <= w_itag[s];
            end
         end
      end
   end

   assign w_full    = r_neg[NSTAGE-1] ? -r_pp[NSTAGE-1] : r_pp[NSTAGE-1];
   assign out_valid = r_v[NSTAGE-1];
   assign product   = r_hi[NSTAGE-1] ? w_full[PW-1:XLEN] : w_full[XLEN-1:0];
   assign out_tag   = r_tag[NSTAGE-1];
endmodule

// File: tb/tb_mult_pipe_param.sv
// tb_mult_pipe_param: directed vectors for mult_pipe_param with hand-computed products.
module tb_mult_pipe_param;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] mcand = '0;
   logic [63:0] mplier = '0;
   logic [1:0]  in_signed = '0;
   logic        in_high = 1'b0;
   logic [5:0]  in_tag = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] product;
   logic [5:0]  out_tag;
   int          n_chk = 0;
   int          n_err = 0;

   mult_pipe_param #(.XLEN(64), .NSTAGE(8), .TAGW(6)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .mcand(mcand), .mplier(mplier), .in_signed(in_signed), .in_high(in_high),
      .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .out_tag(out_tag)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [63:0] mc, input logic [63:0] mp, input logic [1:0] sg,
                        input logic hi, input logic [5:0] t);
      in_valid  = 1'b1;
      mcand     = mc;
      mplier    = mp;
      in_signed = sg;
      in_high   = hi;
      in_tag    = t;
   endtask

   task automatic single(input string tg, input logic [63:0] mc, input logic [63:0] mp,
                         input logic [1:0] sg, input logic hi, input logic [5:0] t,
                         input logic [63:0] exp);
      chk({tg, " in_ready"}, 64'(in_ready), 64'd1);
      drive(mc, mp, sg, hi, t);
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      chk({tg, " early"}, 64'(out_valid), 64'd0);
      tick();
      chk({tg, " valid"}, 64'(out_valid), 64'd1);
      chk({tg, " product"}, product, exp);
      chk({tg, " tag"}, 64'(out_tag), 64'(t));
      tick();
      chk({tg, " drained"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int sent, got, bad;
      logic acc;
      repeat (3) @(posedge clock);
      #1;
      chk("rst hold valid", 64'(out_valid), 64'd0);
      chk("rst hold product", product, 64'd0);
      reset = 1'b1;
      #1;
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst product", product, 64'd0);
      chk("rst out_tag", 64'(out_tag), 64'd0);
      chk("rst in_ready", 64'(in_ready), 64'd1);
      tick();

      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 6'd1);
      tick();
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 6'd2);
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      chk("ones early", 64'(out_valid), 64'd0);
      tick();
      chk("ones hi valid", 64'(out_valid), 64'd1);
      chk("ones hi product", product, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("ones hi tag", 64'(out_tag), 64'd1);
      tick();
      chk("ones lo valid", 64'(out_valid), 64'd1);
      chk("ones lo product", product, 64'h0000_0000_0000_0001);
      chk("ones lo tag", 64'(out_tag), 64'd2);
      tick();
      chk("ones drained", 64'(out_valid), 64'd0);

      single("mulh minneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b1, 6'd3,
             64'h4000_0000_0000_0000);
      single("mul minneg lo", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0, 6'd4,
             64'h0);
      single("mulhsu hi", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b1, 6'd5,
             64'hFFFF_FFFF_FFFF_FFFF);
      single("mulhsu lo", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 6'd6,
             64'h0000_0000_0000_0001);
      single("mulh -3x5 hi", -64'sd3, 64'd5, 2'b11, 1'b1, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      single("mul -3x5 lo", -64'sd3, 64'd5, 2'b11, 1'b0, 6'd8, 64'hFFFF_FFFF_FFFF_FFF1);
      single("mul big lo", 64'd123456789, 64'd987654321, 2'b00, 1'b0, 6'd9, 64'd121932631112635269);
      single("mplier signed", 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 6'd10,
             64'hFFFF_FFFF_FFFF_FFFE);
      single("mulhu 2^63sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 1'b1, 6'd11,
             64'h4000_0000_0000_0000);

      // Backpressure: out_ready low for the first 20 cycles while tags 0..19 are offered.
      sent = 0;
      got = 0;
      for (int c = 0; c < 300 && got < 20; c++) begin
         in_valid  = (sent < 20);
         in_tag    = 6'(sent);
         mcand     = 64'(sent + 1);
         mplier    = 64'd3;
         in_signed = 2'b00;
         in_high   = 1'b0;
         out_ready = (c >= 20);
         #1;
         acc = in_valid && in_ready;
         if (c == 10) chk("bp stable mid", product, 64'd3);
         if (c == 19) begin
            chk("bp accepted", 64'(sent), 64'd8);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp product", product, 64'd3);
            chk("bp out_tag", 64'(out_tag), 64'd0);
         end
         if (out_valid && out_ready) begin
            chk("bp order tag", 64'(out_tag), 64'(got));
            chk("bp order product", product, 64'((got + 1) * 3));
            got++;
         end
         @(posedge clock);
         #1;
         if (acc) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp received", 64'(got), 64'd20);
      tick();
      chk("bp no dup", 64'(out_valid), 64'd0);

      for (int i = 0; i < 3; i++) begin
         drive(64'd11, 64'd13, 2'b00, 1'b0, 6'(40 + i));
         tick();
      end
      in_valid = 1'b0;
      flush = 1'b1;
      #1;
      chk("flush in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) bad++;
         tick();
      end
      chk("flush discarded", 64'(bad), 64'd0);
      single("post flush", 64'd5, 64'd7, 2'b00, 1'b0, 6'd43, 64'd35);

      // Stack five operations against a stalled output, then drop reset between edges.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(64'd9, 64'd9, 2'b00, 1'b0, 6'(50 + i));
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      chk("pre-rst valid", 64'(out_valid), 64'd1);
      chk("pre-rst product", product, 64'd81);
      #3;
      reset = 1'b0;
      #1;
      chk("async rst valid", 64'(out_valid), 64'd0);
      chk("async rst product", product, 64'd0);
      chk("async rst tag", 64'(out_tag), 64'd0);
      repeat (2) tick();
      reset = 1'b1;
      out_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) bad++;
         tick();
      end
      chk("no stale after rst", 64'(bad), 64'd0);
      single("post rst", 64'd6, 64'd7, 2'b00, 1'b0, 6'd60, 64'd42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
